// File: rtl/dm_writeback_cache.sv
// Direct-mapped write-back, write-allocate cache between a 32-bit CPU word port
// and a 256-bit line port. Register storage; misses evict dirty victims then fill.
module dm_writeback_cache #(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5,
  parameter int S_TAG    = 32 - S_INDEX - S_OFFSET
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);
  localparam int SETS   = 2 ** S_INDEX;
  localparam int S_LINE = 32 - S_OFFSET;

  typedef enum logic [1:0] {IDLE, RESP, WB, FILL} state_t;

  state_t              state_q, state_d;
  logic [SETS-1:0]     valid_q, valid_d, dirty_q, dirty_d;
  logic [S_TAG-1:0]    tag_q [SETS];
  logic [S_TAG-1:0]    tag_d [SETS];
  logic [255:0]        data_q [SETS];
  logic [255:0]        data_d [SETS];
  logic [S_LINE-1:0]   req_line_q, req_line_d;
  logic [31:0]         mem_rdata_q, mem_rdata_d;
  logic                mem_resp_q, mem_resp_d;
  logic                pmem_read_q, pmem_read_d;
  logic                pmem_write_q, pmem_write_d;
  logic [31:0]         pmem_address_q, pmem_address_d;
  logic [255:0]        pmem_wdata_q, pmem_wdata_d;

  logic [S_TAG-1:0]    cpu_tag, req_tag;
  logic [S_INDEX-1:0]  cpu_idx, req_idx;
  logic [2:0]          cpu_word;
  logic [7:0]          word_sh;
  logic                cpu_req, cpu_hit;
  logic [31:0]         be_mask;
  logic [255:0]        line_mask, line_wdata;
  logic                unused_addr_bits;

  assign cpu_tag    = mem_address[31 -: S_TAG];
  assign cpu_idx    = mem_address[S_OFFSET +: S_INDEX];
  assign cpu_word   = mem_address[4:2];
  assign word_sh    = {cpu_word, 5'b00000};
  assign req_tag    = req_line_q[S_LINE-1 -: S_TAG];
  assign req_idx    = req_line_q[S_INDEX-1:0];
  assign cpu_req    = mem_read | mem_write;
  assign cpu_hit    = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign be_mask    = {{8{mem_byte_enable[3]}}, {8{mem_byte_enable[2]}},
                       {8{mem_byte_enable[1]}}, {8{mem_byte_enable[0]}}};
  assign line_mask  = {224'b0, be_mask} << word_sh;
  assign line_wdata = {224'b0, mem_wdata} << word_sh;
  assign unused_addr_bits = ^mem_address[1:0];

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    tag_d          = tag_q;
    data_d         = data_q;
    req_line_d     = req_line_q;
    mem_rdata_d    = mem_rdata_q;
    mem_resp_d     = 1'b0;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    case (state_q)
      IDLE: if (cpu_req) begin
        req_line_d = mem_address[31:S_OFFSET];
        if (cpu_hit) begin
          // write wins when both strobes are up
          if (mem_write) begin
            data_d[cpu_idx]  = (data_q[cpu_idx] & ~line_mask) | (line_wdata & line_mask);
            dirty_d[cpu_idx] = 1'b1;
          end else begin
            mem_rdata_d = data_q[cpu_idx][word_sh +: 32];
          end
          mem_resp_d = 1'b1;
          state_d    = RESP;
        end else if (valid_q[cpu_idx] && dirty_q[cpu_idx]) begin
          pmem_write_d   = 1'b1;
          pmem_address_d = {tag_q[cpu_idx], cpu_idx, {S_OFFSET{1'b0}}};
          pmem_wdata_d   = data_q[cpu_idx];
          state_d        = WB;
        end else begin
          pmem_read_d    = 1'b1;
          pmem_address_d = {mem_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
          state_d        = FILL;
        end
      end
      RESP: state_d = IDLE;
      WB: if (pmem_resp) begin
        dirty_d[req_idx] = 1'b0;
        pmem_write_d     = 1'b0;
        state_d          = FILL;
      end
      FILL: begin
        // after a writeback the read is raised one cycle late, leaving a gap
        if (!pmem_read_q) begin
          pmem_read_d    = 1'b1;
          pmem_address_d = {req_line_q, {S_OFFSET{1'b0}}};
        end else if (pmem_resp) begin
          data_d[req_idx]  = pmem_rdata;
          tag_d[req_idx]   = req_tag;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          pmem_read_d      = 1'b0;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      valid_q        <= '0;
      dirty_q        <= '0;
      req_line_q     <= '0;
      mem_rdata_q    <= '0;
      mem_resp_q     <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      dirty_q        <= dirty_d;
      req_line_q     <= req_line_d;
      mem_rdata_q    <= mem_rdata_d;
      mem_resp_q     <= mem_resp_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  // Tag and data contents are don't-care after reset; valid bits guard them.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign mem_rdata    = mem_rdata_q;
  assign mem_resp     = mem_resp_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
endmodule

// File: tb/tb_dm_writeback_cache.sv
// Directed bench: table of hit vectors plus hand sequences for misses, writeback,
// reset abort and a slow adaptor; a small line-memory model plays the adaptor.
module tb_dm_writeback_cache;
  logic         clk, rst;
  logic [31:0]  mem_address, mem_wdata, mem_rdata, pmem_address;
  logic         mem_read, mem_write, mem_resp, pmem_read, pmem_write, pmem_resp;
  logic [3:0]   mem_byte_enable;
  logic [255:0] pmem_wdata, pmem_rdata;

  dm_writeback_cache dut (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_address(pmem_address),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0, bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // adaptor model
  logic [255:0] mem [logic [31:0]];
  int           resp_delay = 1, cnt = 0, n_wb = 0, n_fill = 0;
  bit           adaptor_en = 1'b1, inject = 1'b0;
  logic [31:0]  wb_addr = '0, fill_addr = '0;
  logic [255:0] wb_data = '0;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    if (mem.exists(a)) return mem[a];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'hA500_0000 | a | w;
    return l;
  endfunction

  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pmem_resp) pmem_resp = 1'b0;
      else if (inject) begin
        pmem_resp = 1'b1;
        inject    = 1'b0;
      end else if (adaptor_en && !rst && (pmem_read || pmem_write)) begin
        cnt++;
        if (cnt >= resp_delay) begin
          cnt = 0;
          if (pmem_write) begin
            mem[pmem_address] = pmem_wdata;
            wb_addr = pmem_address;
            wb_data = pmem_wdata;
            n_wb++;
          end else begin
            pmem_rdata = line_of(pmem_address);
            fill_addr  = pmem_address;
            n_fill++;
          end
          pmem_resp = 1'b1;
        end
      end else cnt = 0;
    end
  end

  // protocol monitor
  int           resp_cnt = 0, overlap_err = 0, stab_err = 0, seq_err = 0;
  logic         prev_rd = 1'b0, prev_wr = 1'b0;
  logic [31:0]  prev_addr = '0;
  logic [255:0] prev_wdata = '0;

  initial forever begin
    @(negedge clk);
    if (mem_resp) resp_cnt++;
    if (pmem_read && pmem_write) overlap_err++;
    if ((prev_wr && pmem_read) || (prev_rd && pmem_write)) seq_err++;
    if (((prev_rd && pmem_read) || (prev_wr && pmem_write)) &&
        (pmem_address !== prev_addr || pmem_wdata !== prev_wdata)) stab_err++;
    prev_rd    = pmem_read;
    prev_wr    = pmem_write;
    prev_addr  = pmem_address;
    prev_wdata = pmem_wdata;
  end

  task automatic access(input logic [31:0] a, input bit wr, input bit both,
                        input logic [3:0] be, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
    bit done;
    @(negedge clk);
    mem_address = a;
    mem_read = !wr || both;
    mem_write = wr;
    mem_byte_enable = be;
    mem_wdata = wd;
    lat = 0;
    rd = '0;
    done = 1'b0;
    for (int i = 1; i <= 400 && !done; i++) begin
      @(posedge clk); #1;
      if (mem_resp) begin
        lat = i;
        rd = mem_rdata;
        done = 1'b1;
      end
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL access_timeout: addr %h got no mem_resp want one", a);
    end
    @(posedge clk); #1;
    check("resp_one_cycle", 32'(mem_resp), 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    bit          both;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt[10];
  logic [31:0] rd;
  int          lat, f0, w0, r0;

  initial begin
    vt[0] = '{32'h0000_0104, 1'b0, 1'b0, 4'b0000, 32'h0, 32'hDEAD_BEEF};
    vt[1] = '{32'h0000_0100, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h1000_0000};
    vt[2] = '{32'h0000_011C, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h1000_0007};
    vt[3] = '{32'h0000_0104, 1'b1, 1'b0, 4'b0011, 32'h1234_5678, 32'h0};
    vt[4] = '{32'h0000_0104, 1'b0, 1'b0, 4'b0000, 32'h0, 32'hDEAD_5678};
    vt[5] = '{32'h0000_0108, 1'b1, 1'b0, 4'b0000, 32'hFFFF_FFFF, 32'h0};
    vt[6] = '{32'h0000_0108, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h1000_0002};
    vt[7] = '{32'h0000_010C, 1'b1, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vt[8] = '{32'h0000_010C, 1'b0, 1'b0, 4'b0000, 32'h0, 32'hCAFE_F00D};
    vt[9] = '{32'h0000_0113, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h1000_0004};

    begin
      logic [255:0] l0, l1;
      for (int w = 0; w < 8; w++) begin
        l0[w*32 +: 32] = 32'h1000_0000 + w;
        l1[w*32 +: 32] = 32'h2000_0000 + w;
      end
      l0[63:32] = 32'hDEAD_BEEF;
      mem[32'h0000_0100] = l0;
      mem[32'h0000_1100] = l1;
    end

    rst = 1'b1;
    mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = '0; mem_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_resp", 32'(mem_resp), 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_pmem_rw", {30'd0, pmem_read, pmem_write}, 32'd0);
    check("rst_pmem_address", pmem_address, 32'd0);
    check("rst_pmem_wdata", 32'(|pmem_wdata), 32'd0);
    @(negedge clk); rst = 1'b0;

    // clean miss fill
    access(32'h0000_0104, 1'b0, 1'b0, 4'b0, 32'h0, rd, lat);
    check("miss_rdata", rd, 32'hDEAD_BEEF);
    check("miss_fill_addr", fill_addr, 32'h0000_0100);
    check("miss_n_fill", 32'(n_fill), 32'd1);
    check("miss_no_wb", 32'(n_wb), 32'd0);
    check("miss_resp_pulses", 32'(resp_cnt), 32'd1);

    // hits: one-cycle latency, no line traffic
    for (int i = 0; i < 10; i++) begin
      f0 = n_fill; w0 = n_wb; r0 = resp_cnt;
      access(vt[i].addr, vt[i].wr, vt[i].both, vt[i].be, vt[i].wdata, rd, lat);
      check($sformatf("hit%0d_latency", i), 32'(lat), 32'd1);
      check($sformatf("hit%0d_no_pmem", i), 32'((n_fill - f0) + (n_wb - w0)), 32'd0);
      check($sformatf("hit%0d_one_resp", i), 32'(resp_cnt - r0), 32'd1);
      if (!vt[i].wr) check($sformatf("hit%0d_rdata", i), rd, vt[i].exp);
    end

    // dirty miss: writeback of the merged line, then fill of the new tag
    access(32'h0000_1104, 1'b0, 1'b0, 4'b0, 32'h0, rd, lat);
    check("dirty_n_wb", 32'(n_wb), 32'd1);
    check("dirty_wb_addr", wb_addr, 32'h0000_0100);
    check("dirty_wb_w1", wb_data[63:32], 32'hDEAD_5678);
    check("dirty_wb_w2", wb_data[95:64], 32'h1000_0002);
    check("dirty_wb_w3", wb_data[127:96], 32'hCAFE_F00D);
    check("dirty_fill_addr", fill_addr, 32'h0000_1100);
    check("dirty_rdata", rd, 32'h2000_0001);

    // reset while WB is pending
    access(32'h0000_1100, 1'b1, 1'b0, 4'b1111, 32'h55AA_55AA, rd, lat);
    adaptor_en = 1'b0;
    w0 = n_wb; f0 = n_fill;
    @(negedge clk);
    mem_address = 32'h0000_0104; mem_read = 1'b1;
    for (int i = 0; i < 20 && !pmem_write; i++) begin
      @(posedge clk); #1;
    end
    check("abort_wb_active", 32'(pmem_write), 32'd1);
    check("abort_wb_addr", pmem_address, 32'h0000_1100);
    @(negedge clk); rst = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    check("abort_outputs", {28'd0, pmem_read, pmem_write, mem_resp, |pmem_wdata}, 32'd0);
    check("abort_addr", pmem_address, 32'd0);
    @(negedge clk); rst = 1'b0; adaptor_en = 1'b1;
    r0 = resp_cnt;
    inject = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("stray_resp_ignored", {29'd0, pmem_read, pmem_write, mem_resp}, 32'd0);
    check("stray_resp_no_pulse", 32'(resp_cnt - r0), 32'd0);
    access(32'h0000_0104, 1'b0, 1'b0, 4'b0, 32'h0, rd, lat);
    check("post_rst_no_wb", 32'(n_wb - w0), 32'd0);
    check("post_rst_fill", 32'(n_fill - f0), 32'd1);
    check("post_rst_rdata", rd, 32'hDEAD_5678);

    // slow adaptor on a fill
    resp_delay = 20;
    r0 = resp_cnt;
    access(32'h0000_0224, 1'b0, 1'b0, 4'b0, 32'h0, rd, lat);
    check("slow_fill_addr", fill_addr, 32'h0000_0220);
    check("slow_rdata", rd, 32'hA500_0221);
    check("slow_latency_gt20", 32'(lat > 20), 32'd1);
    check("slow_one_resp", 32'(resp_cnt - r0), 32'd1);

    check("proto_overlap", 32'(overlap_err), 32'd0);
    check("proto_gap", 32'(seq_err), 32'd0);
    check("proto_stable", 32'(stab_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
